// File: rtl/counter_pkg.sv
// Shared types and constants for the counter family.
package counter_pkg;

    localparam int unsigned WRAP_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        ONE_SHOT    = 1'b0,
        AUTO_RELOAD = 1'b1
    } mode_e;

    function automatic logic [WRAP_W-1:0] sat_inc(input logic [WRAP_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Advance-enable generator: one tick every PRESCALE enabled cycles.
// Instantiated by up_counter_ctl only when UP_COUNTER_PRESCALE_EN is defined.
module tick_prescaler #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/up_counter_ctl.sv
// Controlled up counter with start/stop, programmable limit, one-shot or auto-reload.
// Define UP_COUNTER_PRESCALE_EN to advance only once every PRESCALE RUN cycles.
module up_counter_ctl
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned PRESCALE = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              mode,
    input  logic [WIDTH-1:0]  limit,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    output logic [WIDTH-1:0]  count,
    output logic              busy,
    output logic              tc,
    output logic              done,
    output logic [WRAP_W-1:0] wraps
);

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [WIDTH-1:0]  limit_q, limit_d;
    logic [WIDTH-1:0]  count_q, count_d;
    logic [WRAP_W-1:0] wraps_q, wraps_d;
    logic              tc_q, tc_d;
    logic              advance_en;

`ifdef UP_COUNTER_PRESCALE_EN
    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (start | stop | load),
        .en    (state_q == RUN),
        .tick  (advance_en)
    );
`else
    logic unused_prescale;
    assign unused_prescale = ^PRESCALE;
    assign advance_en      = 1'b1;
`endif

    // Priority: load > stop > start > advance. Stop in IDLE is a no-op, so a
    // simultaneous start still takes effect there.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        mode_d  = mode_q;
        limit_d = limit_q;
        count_d = count_q;
        wraps_d = wraps_q;
        tc_d    = 1'b0;

        if (load) begin
            count_d = load_val;
        end else if (stop && (state_q != IDLE)) begin
            state_d = IDLE;
        end else if (start) begin
            state_d = RUN;
            count_d = '0;
            wraps_d = '0;
            mode_d  = mode_e'(mode);
            limit_d = limit;
        end else if ((state_q == RUN) && advance_en) begin
            if (count_q != limit_q) begin
                count_d = count_q + 1'b1;
            end else begin
                tc_d = 1'b1;
                if (mode_q == AUTO_RELOAD) begin
                    count_d = '0;
                    wraps_d = sat_inc(wraps_q);
                end else begin
                    state_d = DONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            mode_q  <= ONE_SHOT;
            limit_q <= '0;
            count_q <= '0;
            wraps_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            limit_q <= limit_d;
            count_q <= count_d;
            wraps_q <= wraps_d;
            tc_q    <= tc_d;
        end
    end

    assign count = count_q;
    assign wraps = wraps_q;
    assign tc    = tc_q;
    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);

endmodule

// File: tb/tb_up_counter_ctl.sv
// Directed self-checking bench for up_counter_ctl (WIDTH=4).
module tb_up_counter_ctl;

`ifdef UP_COUNTER_PRESCALE_EN
    localparam int unsigned PS = 4;
`else
    localparam int unsigned PS = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] limit = '0;
    logic       load = 1'b0;
    logic [3:0] load_val = '0;
    logic [3:0] count;
    logic       busy, tc, done;
    logic [7:0] wraps;

    int n_tests = 0;
    int n_fail  = 0;

    up_counter_ctl #(
        .WIDTH    (4),
        .PRESCALE (PS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .mode     (mode),
        .limit    (limit),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .busy     (busy),
        .tc       (tc),
        .done     (done),
        .wraps    (wraps)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; sample and drive 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic m, input logic [3:0] lim);
        start = 1'b1;
        mode  = m;
        limit = lim;
        tick();
        start = 1'b0;
    endtask

`ifdef UP_COUNTER_PRESCALE_EN
    task automatic run_prescale();
        int exp_cnt [12] = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 2};
        do_start(1'b0, 4'd2);
        check("ps_start_cnt", int'(count), 0);
        for (int c = 1; c <= 12; c++) begin
            tick();
            check($sformatf("ps_cnt_%0d", c), int'(count), exp_cnt[c-1]);
            check($sformatf("ps_done_%0d", c), int'(done), (c == 12) ? 1 : 0);
            check($sformatf("ps_tc_%0d", c), int'(tc), (c == 12) ? 1 : 0);
        end
    endtask
`else
    task automatic run_main();
        int ar_cnt [12] = '{1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0};
        int ld_cnt [7]  = '{14, 15, 0, 1, 2, 3, 0};

        // One-shot, limit 5
        do_start(1'b0, 4'd5);
        check("os_start_cnt", int'(count), 0);
        check("os_start_busy", int'(busy), 1);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("os_cnt_%0d", i), int'(count), i);
            check($sformatf("os_tc_%0d", i), int'(tc), 0);
        end
        tick();
        check("os_term_tc", int'(tc), 1);
        check("os_term_done", int'(done), 1);
        check("os_term_busy", int'(busy), 0);
        check("os_term_cnt", int'(count), 5);
        tick();
        check("os_hold_tc", int'(tc), 0);
        check("os_hold_done", int'(done), 1);
        check("os_hold_cnt", int'(count), 5);

        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_done_idle", int'(done), 0);
        check("stop_done_cnt", int'(count), 5);

        // Auto-reload, limit 3, 12 cycles
        do_start(1'b1, 4'd3);
        check("ar_start_cnt", int'(count), 0);
        for (int i = 0; i < 12; i++) begin
            tick();
            check($sformatf("ar_cnt_%0d", i), int'(count), ar_cnt[i]);
            check($sformatf("ar_tc_%0d", i), int'(tc), (i % 4 == 3) ? 1 : 0);
        end
        check("ar_wraps", int'(wraps), 3);
        check("ar_busy", int'(busy), 1);

        // Load above the limit while running
        load     = 1'b1;
        load_val = 4'd14;
        tick();
        load = 1'b0;
        check("ld_cnt_0", int'(count), ld_cnt[0]);
        check("ld_tc_0", int'(tc), 0);
        for (int i = 1; i < 7; i++) begin
            tick();
            check($sformatf("ld_cnt_%0d", i), int'(count), ld_cnt[i]);
            check($sformatf("ld_tc_%0d", i), int'(tc), (i == 6) ? 1 : 0);
        end
        check("ld_wraps", int'(wraps), 4);

        // Reset mid-run at count 5
        do_start(1'b0, 4'd10);
        for (int i = 0; i < 5; i++) tick();
        check("rst_pre_cnt", int'(count), 5);
        reset = 1'b1;
        #2;
        check("rst_cnt", int'(count), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_tc", int'(tc), 0);
        check("rst_wraps", int'(wraps), 0);
        tick();
        reset = 1'b0;
        tick();
        check("rst_stays_idle", int'(busy), 0);

        // start + stop together in IDLE: start wins
        start = 1'b1;
        stop  = 1'b1;
        mode  = 1'b0;
        limit = 4'd2;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("ss_busy", int'(busy), 1);
        check("ss_cnt", int'(count), 0);
        for (int i = 0; i < 3; i++) tick();
        check("ss_done", int'(done), 1);
        check("ss_tc", int'(tc), 1);

        // load + start together in DONE: load wins, state stays DONE
        load     = 1'b1;
        load_val = 4'd9;
        start    = 1'b1;
        mode     = 1'b1;
        limit    = 4'd7;
        tick();
        load  = 1'b0;
        start = 1'b0;
        check("ls_cnt", int'(count), 9);
        check("ls_done", int'(done), 1);
        check("ls_busy", int'(busy), 0);
        check("ls_tc", int'(tc), 0);

        // limit 0, one-shot: DONE one cycle after start
        do_start(1'b0, 4'd0);
        check("l0os_busy", int'(busy), 1);
        check("l0os_tc0", int'(tc), 0);
        tick();
        check("l0os_done", int'(done), 1);
        check("l0os_tc", int'(tc), 1);
        check("l0os_cnt", int'(count), 0);

        // limit 0, auto-reload: tc every cycle, then wraps saturates
        do_start(1'b1, 4'd0);
        check("l0ar_tc0", int'(tc), 0);
        check("l0ar_wraps0", int'(wraps), 0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("l0ar_tc_%0d", i), int'(tc), 1);
            check($sformatf("l0ar_cnt_%0d", i), int'(count), 0);
        end
        check("l0ar_wraps3", int'(wraps), 3);
        for (int i = 0; i < 300; i++) tick();
        check("wraps_sat", int'(wraps), 255);
        check("wraps_sat_tc", int'(tc), 1);

        // limit all-ones, one-shot: no natural wrap before the terminal event
        do_start(1'b0, 4'd15);
        for (int i = 0; i < 15; i++) tick();
        check("l15_cnt", int'(count), 15);
        check("l15_tc_pre", int'(tc), 0);
        check("l15_busy", int'(busy), 1);
        tick();
        check("l15_tc", int'(tc), 1);
        check("l15_done", int'(done), 1);
        check("l15_cnt_hold", int'(count), 15);

        // Stop during RUN holds the count
        do_start(1'b0, 4'd9);
        for (int i = 0; i < 3; i++) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_run_cnt", int'(count), 3);
        check("stop_run_busy", int'(busy), 0);
        check("stop_run_done", int'(done), 0);
        tick();
        check("stop_run_hold", int'(count), 3);
    endtask
`endif

    initial begin
        tick();
        tick();
        reset = 1'b0;
        check("init_cnt", int'(count), 0);
        check("init_busy", int'(busy), 0);
        check("init_done", int'(done), 0);
        check("init_tc", int'(tc), 0);
        check("init_wraps", int'(wraps), 0);
`ifdef UP_COUNTER_PRESCALE_EN
        run_prescale();
`else
        run_main();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/up_counter_ctl.md
Name: up_counter_ctl

Overview:
- Controlled N-bit up counter; the up-counting counterpart to the existing down counter in the counter family.
- Adds start/stop control, a programmable terminal value (limit), one-shot or auto-reload modes, a synchronous load, a terminal-count pulse and a saturating wrap counter.
- Used as a timer/event sequencer driven by a local controller.

Parameters:
WIDTH, 4, count and limit width in bits (WIDTH >= 2)
PRESCALE, 4, clock cycles per count advance; only used when UP_COUNTER_PRESCALE_EN is defined (PRESCALE >= 1)

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  begin counting from 0; latches mode and limit
stop  input  1  abort the run; return to IDLE holding count
mode  input  1  0 = one-shot, 1 = auto-reload; sampled on start only
limit  input  WIDTH  terminal value; sampled on start only
load  input  1  synchronous load of load_val into count
load_val  input  WIDTH  value for load
count  output  WIDTH  current count, registered
busy  output  1  high in RUN state
tc  output  1  one-cycle pulse, registered, on each terminal event
done  output  1  high in DONE state (one-shot complete)
wraps  output  8  number of auto-reload wraps since start; saturates at 255

Behaviour:
- Reset (asynchronous assert, deassert on clk): state=IDLE, count=0, busy=0, tc=0, done=0, wraps=0, latched mode=0, latched limit=0.
- States: IDLE, RUN, DONE. busy = (state==RUN); done = (state==DONE); both are decoded from a registered state.
- Per-cycle priority: reset > load > stop > start > advance.
- load:
  - count<=load_val in any state; state unchanged.
  - No tc in that cycle; no advance in that cycle.
- stop:
  - RUN or DONE -> IDLE; count holds.
  - Ignored in IDLE.
- start:
  - IDLE or DONE -> RUN; count<=0, wraps<=0; latches mode and limit.
  - In RUN: restarts the same way (count<=0, wraps<=0, new mode/limit).
- Advance (RUN only, every cycle; every PRESCALE cycles with the feature enabled):
  - count!=limit: count<=count+1, modulo 2^WIDTH.
  - count==limit, mode=1: count<=0, tc<=1, wraps<=sat(wraps+1); stay in RUN.
  - count==limit, mode=0: count holds at limit, tc<=1, state<=DONE.
- tc: high for exactly one cycle after the terminal edge; 0 otherwise.
- Latency:
  - start sampled at edge k -> count=0, busy=1 after k.
  - First increment after edge k+1.
  - One-shot with limit L: tc and done visible after edge k+L+1.
- Boundary conditions:
  - limit=0, mode=1: tc high every cycle while RUN; count stays 0.
  - limit=0, mode=0: DONE one cycle after start.
  - count>limit (reached via load): counts up through 2^WIDTH-1, wraps to 0 with no tc, then continues to limit.
  - limit=2^WIDTH-1: terminal event at all-ones; no natural wrap precedes it.
  - Reset mid-run: immediate return to the reset values above.

Optional Feature:
- Macro UP_COUNTER_PRESCALE_EN.
- Defined:
  - An internal prescaler generates an advance enable once every PRESCALE cycles while in RUN.
  - The prescaler clears on start, stop, load and reset.
  - Terminal and tc timing scale accordingly; tc stays one clk cycle wide.
- Undefined: advance occurs every RUN cycle; the PRESCALE parameter is ignored and no prescaler logic is built.

Decomposition:
- Package counter_pkg:
  - state enum (IDLE, RUN, DONE)
  - mode enum (ONE_SHOT=0, AUTO_RELOAD=1)
  - WRAP_W=8 constant
- Sub-module tick_prescaler (parameter PRESCALE; ports clk, reset, clr, en, tick), instantiated only under UP_COUNTER_PRESCALE_EN.
- FSM, count datapath and wrap counter stay in up_counter_ctl.

Test Plan:
- Reset mid-run (count=5) -> next sample: count=0, busy=0, done=0, tc=0, wraps=0.
- One-shot: start=1 with mode=0, limit=5 -> count 0..5, tc high one cycle, done=1, count holds at 5, busy=0.
- Auto-reload: start with mode=1, limit=3, run 12 cycles -> count 0,1,2,3,0,…; tc every 4th cycle; wraps=3.
- load_val=14 during RUN with limit=3 -> count 14,15,0,1,2,3; tc only at the 3->0 transition.
- Same-cycle start+stop in IDLE -> stop is ignored, start wins (RUN); same-cycle load+start in DONE -> count=load_val, state stays DONE.
- Feature on, PRESCALE=4, limit=2, one-shot -> count changes every 4 cycles; done after 12 RUN cycles.
